// File: rtl/hall_commutator.sv
// Hall-sensor front end: synchronizes the hall pins, captures rotor position on PWM_synch,
// decodes it into coil selects and drive duty, measures hall period and flags invalid halls.

module hall_sync (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic stable
);
   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta   <= 1'b0;
         stable <= 1'b0;
      end else begin
         meta   <= pin;
         stable <= meta;
      end
   end
endmodule

module hall_commutator #(
   parameter int PER_W   = 16,
   parameter int FLT_CNT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hallGrn,
   input  logic             hallYlw,
   input  logic             hallBlu,
   input  logic             PWM_synch,
   input  logic             en,
   input  logic             brake_n,
   input  logic [11:0]      drv_mag,
   output logic [1:0]       selGrn,
   output logic [1:0]       selYlw,
   output logic [1:0]       selBlu,
   output logic [10:0]      duty,
   output logic [PER_W-1:0] hall_period,
   output logic             hall_vld,
   output logic             hall_fault
);
   localparam logic [PER_W-1:0] PER_MAX  = '1;
   localparam logic [3:0]       FLT_LAST = 4'(FLT_CNT - 1);

   logic [2:0]       pins;
   logic [2:0]       hall;
   logic [2:0]       rot_state;
   logic [PER_W-1:0] cnt;
   logic [PER_W-1:0] per_nxt;
   logic             armed;
   logic [3:0]       flt_cnt;
   logic             change_cap;
   logic             invalid_cap;
   logic [2:0][1:0]  sel_tbl;
   logic [2:0][1:0]  sel_nxt;
   logic [10:0]      duty_nxt;

   assign pins = {hallGrn, hallYlw, hallBlu};

   generate
      for (genvar i = 0; i < 3; i++) begin : g_sync
         hall_sync u_sync (
            .clk    (clk),
            .rst    (rst),
            .pin    (pins[i]),
            .stable (hall[i])
         );
      end
   endgenerate

   function automatic logic valid_pos(input logic [2:0] p);
      return (p != 3'b000) && (p != 3'b111);
   endfunction

   // A rotation step needs both ends valid; glitches through 000/111 never count.
   assign change_cap  = PWM_synch && valid_pos(hall) && valid_pos(rot_state) && (hall != rot_state);
   assign invalid_cap = PWM_synch && !valid_pos(hall);
   assign per_nxt     = (cnt == PER_MAX) ? PER_MAX : cnt + 1'b1;

   always_comb begin
      sel_tbl = '0;
      case (rot_state)
         3'b101: sel_tbl = {2'b10, 2'b01, 2'b00};
         3'b100: sel_tbl = {2'b10, 2'b00, 2'b01};
         3'b110: sel_tbl = {2'b00, 2'b10, 2'b01};
         3'b010: sel_tbl = {2'b01, 2'b10, 2'b00};
         3'b011: sel_tbl = {2'b01, 2'b00, 2'b10};
         3'b001: sel_tbl = {2'b00, 2'b01, 2'b10};
         default: sel_tbl = '0;
      endcase
   end

   always_comb begin
      sel_nxt  = '0;
      duty_nxt = '0;
      if (!en || hall_fault) begin
         sel_nxt  = '0;
         duty_nxt = '0;
      end else if (!brake_n) begin
         sel_nxt  = {2'b11, 2'b11, 2'b11};
         duty_nxt = 11'h600;
      end else begin
         sel_nxt  = sel_tbl;
         // Upper ten magnitude bits on a half-scale offset; the sum tops out at 11'h7FF.
         duty_nxt = 11'h400 + 11'(drv_mag >> 2);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rot_state   <= 3'b000;
         selGrn      <= 2'b00;
         selYlw      <= 2'b00;
         selBlu      <= 2'b00;
         duty        <= '0;
         hall_period <= '0;
         hall_vld    <= 1'b0;
         hall_fault  <= 1'b0;
         cnt         <= '0;
         flt_cnt     <= '0;
         armed       <= 1'b0;
      end else begin
         {selGrn, selYlw, selBlu} <= sel_nxt;
         duty     <= duty_nxt;
         hall_vld <= change_cap && armed;

         if (PWM_synch)
            rot_state <= hall;

         if (change_cap) begin
            cnt   <= '0;
            armed <= 1'b1;
            if (armed)
               hall_period <= per_nxt;
         end else if (cnt != PER_MAX) begin
            cnt <= cnt + 1'b1;
         end

         if (invalid_cap) begin
            if (flt_cnt != 4'hF)
               flt_cnt <= flt_cnt + 1'b1;
            if (flt_cnt == FLT_LAST)
               hall_fault <= 1'b1;
         end else if (PWM_synch) begin
            flt_cnt <= '0;
         end
      end
   end
endmodule
